spi_mem_burst_reader: RTL and testbench
=======================================

# spi_mem_burst_reader

Upstream controller for `spi_memory_master` that turns a single "read N bytes from address A" command into one or more SPI memory read transactions. It drives the master's command inputs and its per-byte `read_data_flag`, collects `read_data` into a small FWFT FIFO, and presents the bytes on a valid/ready stream. When the FIFO cannot absorb more bytes, the block ends the current transaction and resumes later at the next address, so the master is never stalled mid-byte.

## Interface
- `ADDR_WIDTH`, 8: width of the memory address sent to the master.
- `DEPTH`, 4: FIFO depth in bytes (power of two, ≥2).
- `READ_OPCODE`, 8'h03: opcode driven to the master.
- `DUMMY`, 4'd0: dummy cycles driven to the master.
- `main_clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: command strobe, sampled in IDLE only.
- `start_addr` in ADDR_WIDTH: first byte address.
- `length` in 16: byte count.
- `active` out 1: command in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse when the command completes.
- `overflow` out 1: sticky error flag, cleared only by `reset`.
- `opcode` out 8: constant READ_OPCODE.
- `addr` out ADDR_WIDTH: transaction address.
- `dummy_cycles` out 4: constant DUMMY.
- `addr_flag` out 1: constant 1.
- `write_data_flag` out 1: constant 0.
- `write_data` out 8: constant 0.
- `trigger` out 1: transaction request to the master.
- `read_data_flag` out 1: request one more byte.
- `read_data` in 8: byte from the master.
- `read_data_ready` in 1: one-cycle pulse, `read_data` valid.
- `read_data_flag_captured` in 1: master has sampled `read_data_flag`; its rising edge counts.
- `spi_busy` in 1: master `busy`.
- `out_data` out 8: FIFO head.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head.

## Operation
- **Counters** (16 bit, cleared on accepted start):
  - `requested`: +1 on each rising edge of `read_data_flag_captured` (registered previous value) while `read_data_flag`=1.
  - `received`: +1 on each `read_data_ready`.
- **Window condition** `W`: `requested < length` AND `fifo_count + (requested − received) < DEPTH`.
- **`read_data_flag`**: equals `W` in LAUNCH/RUN, 0 elsewhere.
- **`addr`**: `(start_addr + received) mod 2^ADDR_WIDTH`, latched on entry to LAUNCH and held constant through RUN.
- **FSM**:
  - IDLE: on `start`, if `length`=0 go to DONE; otherwise latch `start_addr`/`length`, clear counters, go to CHECK.
  - CHECK: if `received`=`length` go to DONE; else if `W` go to LAUNCH; else stay.
  - LAUNCH: `trigger`=1; when `spi_busy`=1 is sampled, go to RUN.
  - RUN: `trigger`=0; when `spi_busy`=0 is sampled, go to CHECK.
  - DONE: `done`=1 for one cycle, then IDLE.
- **FIFO**:
  - Push on `read_data_ready`; pop on `out_valid && out_ready`.
  - Push and pop may occur in the same cycle, including when full or empty-plus-push. Push into an empty FIFO makes `out_valid`=1 the next cycle.
  - `read_data_ready` arriving while full and not popping: the byte is dropped, `overflow` is set, and `received` still increments.
- **`done` vs. drain**: `done` does not wait for the FIFO to drain; `out_valid` may remain high after `done`.
- **`start` outside IDLE**: ignored.
- **`reset`**: at the next edge, state goes to IDLE, the FIFO empties, and counters clear. `trigger`, `read_data_flag`, `done`, `active`, `out_valid` and `overflow` go to 0, `addr`=0, and `out_data`=0. Reset mid-transaction does not reset the master and produces no `done`.

## Timing
- `start` in cycle t → CHECK in t+1 → LAUNCH in t+2, so `trigger` first goes high at t+2.
- `length`=0: `done` high in cycle t+1.
- `trigger` stays high until the edge at which `spi_busy`=1 is sampled; it is 0 the following cycle.
- `read_data_flag` is combinational from registered state and changes in the cycle after the count that closes the window.
- Relaunch gap: at least 2 cycles after `spi_busy` falls (RUN→CHECK→LAUNCH).
- `done` fires 2 cycles after the `spi_busy` fall of the final transaction (RUN→CHECK→DONE).
- `out_valid` latency from `read_data_ready`: 1 cycle.

## Test plan
- **Single burst**: `start_addr`=0xAB, `length`=3, `out_ready`=1, master model returns 0x11, 0x22, 0x33 → exactly one transaction with `addr`=0xAB and opcode 0x03; 3 captured edges with flag=1, then flag=0; `out_data` sequence 0x11, 0x22, 0x33; one `done` pulse.
- **Zero length**: `length`=0 → `done` in cycle t+1; `trigger` never asserted; `out_valid` stays 0.
- **Backpressure**: `DEPTH`=4, `length`=10, `out_ready`=0 → first transaction reads exactly 4 bytes and the block waits in CHECK with `trigger`=0. Raise `out_ready` → relaunch at `addr`=0xAF. All 10 bytes arrive in order with no `overflow`.
- **Address wrap**: `start_addr`=0xFD, `length`=6, `out_ready`=0 until the first transaction ends, then 1 → second transaction `addr`=0x01.
- **Reset and start interactions**: `start` pulsed during RUN → ignored, counters unchanged. `reset` during RUN → next cycle `trigger`=0, `read_data_flag`=0, `out_valid`=0, `active`=0, and no `done`.
- **Overflow**: with the FIFO full and `out_ready`=0, inject an extra `read_data_ready` with 0x5A → `overflow`=1 and sticky; FIFO contents and `out_data` unchanged.

Source files
------------

// File: rtl/spi_mem_burst_reader.sv
// Turns one "read N bytes from address A" command into as many spi_memory_master
// read transactions as the output FIFO allows, streaming the bytes out in order.
module spi_mem_burst_reader #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          DEPTH       = 4,
    parameter logic [7:0]  READ_OPCODE = 8'h03,
    parameter logic [3:0]  DUMMY       = 4'd0
) (
    input  logic                  main_clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [15:0]           length,
    output logic                  active,
    output logic                  done,
    output logic                  overflow,
    output logic [7:0]            opcode,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [3:0]            dummy_cycles,
    output logic                  addr_flag,
    output logic                  write_data_flag,
    output logic [7:0]            write_data,
    output logic                  trigger,
    output logic                  read_data_flag,
    input  logic [7:0]            read_data,
    input  logic                  read_data_ready,
    input  logic                  read_data_flag_captured,
    input  logic                  spi_busy,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            state_dbg
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                state;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [15:0]           requested;
    logic [15:0]           received;
    logic                  captured_q;

    logic [7:0]            mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;

    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  captured_rise;
    logic [15:0]           in_flight;
    logic [16:0]           occupancy;
    logic                  window;

    assign opcode          = READ_OPCODE;
    assign dummy_cycles    = DUMMY;
    assign addr_flag       = 1'b1;
    assign write_data_flag = 1'b0;
    assign write_data      = 8'h00;
    assign active          = (state != ST_IDLE);
    assign state_dbg       = state;

    // Output stream: a byte transfers on every cycle where out_valid && out_ready
    // at the rising clock edge; out_valid never depends on out_ready.
    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_full = (fifo_count == CW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = read_data_ready && (!fifo_full || pop);

    // Bytes already requested but not yet returned still need a FIFO slot.
    assign in_flight      = requested - received;
    assign occupancy      = 17'(fifo_count) + {1'b0, in_flight};
    assign window         = (requested < len_q) && (occupancy < 17'(DEPTH));
    assign read_data_flag = window && ((state == ST_LAUNCH) || (state == ST_RUN));
    assign captured_rise  = read_data_flag_captured && !captured_q;

    always_ff @(posedge main_clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= read_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (read_data_ready && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            base_addr  <= '0;
            requested  <= '0;
            received   <= '0;
            captured_q <= 1'b0;
            addr       <= '0;
            trigger    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= 1'b0;
            captured_q <= read_data_flag_captured;
            if (captured_rise && read_data_flag) begin
                requested <= requested + 16'd1;
            end
            // A dropped overflow byte still counts, so the address stays in step.
            if (read_data_ready) begin
                received <= received + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == 16'd0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            len_q     <= length;
                            base_addr <= start_addr;
                            requested <= '0;
                            received  <= '0;
                            state     <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (received == len_q) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (window) begin
                        state   <= ST_LAUNCH;
                        trigger <= 1'b1;
                        addr    <= base_addr + ADDR_WIDTH'(received);
                    end
                end
                ST_LAUNCH: begin
                    if (spi_busy) begin
                        state   <= ST_RUN;
                        trigger <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!spi_busy) begin
                        state <= ST_CHECK;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_burst_reader.sv
// Directed bench for spi_mem_burst_reader: a behavioural SPI master answers
// transactions, a scoreboard queue checks the output stream byte by byte.
module tb_spi_mem_burst_reader;

    logic        main_clock;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic [15:0] length;
    logic        active;
    logic        done;
    logic        overflow;
    logic [7:0]  opcode;
    logic [7:0]  addr;
    logic [3:0]  dummy_cycles;
    logic        addr_flag;
    logic        write_data_flag;
    logic [7:0]  write_data;
    logic        trigger;
    logic        read_data_flag;
    logic [7:0]  read_data;
    logic        read_data_ready;
    logic        read_data_flag_captured;
    logic        spi_busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int trig_cnt = 0;
    logic trig_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] src_q[$];

    spi_mem_burst_reader dut (
        .main_clock              (main_clock),
        .reset                   (reset),
        .start                   (start),
        .start_addr              (start_addr),
        .length                  (length),
        .active                  (active),
        .done                    (done),
        .overflow                (overflow),
        .opcode                  (opcode),
        .addr                    (addr),
        .dummy_cycles            (dummy_cycles),
        .addr_flag               (addr_flag),
        .write_data_flag         (write_data_flag),
        .write_data              (write_data),
        .trigger                 (trigger),
        .read_data_flag          (read_data_flag),
        .read_data               (read_data),
        .read_data_ready         (read_data_ready),
        .read_data_flag_captured (read_data_flag_captured),
        .spi_busy                (spi_busy),
        .out_data                (out_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .state_dbg               (state_dbg)
    );

    // Clock and reset
    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge main_clock);
    endtask

    task automatic do_start(input logic [7:0] a, input logic [15:0] l);
        start      = 1'b1;
        start_addr = a;
        length     = l;
        @(negedge main_clock);
        start = 1'b0;
    endtask

    // Behavioural master. inject=1 pulses start mid-RUN, inject=2 resets mid-RUN.
    task automatic master_txn(input int inject, input logic [7:0] exp_addr, output int nbytes);
        int  waited;
        bit  f;
        bit  ended;
        nbytes = 0;
        waited = 0;
        ended  = 1'b0;
        while (!trigger && waited < 50) begin
            @(negedge main_clock);
            waited++;
        end
        check("trigger_seen", trigger, 1);
        if (!trigger) return;
        check("txn_addr", addr, exp_addr);
        spi_busy = 1'b1;
        @(negedge main_clock);
        check("trigger_drop", trigger, 0);
        for (int i = 0; i < 20; i++) begin
            f = read_data_flag;
            read_data_flag_captured = 1'b1;
            @(negedge main_clock);
            read_data_flag_captured = 1'b0;
            if (!f) begin
                ended = 1'b1;
                break;
            end
            @(negedge main_clock);
            read_data       = (src_q.size() != 0) ? src_q.pop_front() : 8'hEE;
            read_data_ready = 1'b1;
            @(negedge main_clock);
            read_data_ready = 1'b0;
            nbytes++;
            if (nbytes == 1 && inject == 1) begin
                start      = 1'b1;
                start_addr = 8'h99;
                length     = 16'd5;
                @(negedge main_clock);
                start = 1'b0;
                @(negedge main_clock);
                check("start_ignored_state", state_dbg, 3);
                check("start_ignored_addr", addr, exp_addr);
            end
            if (nbytes == 1 && inject == 2) begin
                reset = 1'b1;
                @(negedge main_clock);
                check("rst_trigger", trigger, 0);
                check("rst_flag", read_data_flag, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_active", active, 0);
                check("rst_done", done, 0);
                check("rst_out_data", out_data, 0);
                check("rst_addr", addr, 0);
                reset    = 1'b0;
                spi_busy = 1'b0;
                return;
            end
        end
        check("txn_terminated", ended, 1);
        spi_busy = 1'b0;
    endtask

    // Scoreboard / event monitor, sampled mid-low-phase after the drivers settle
    always begin
        @(negedge main_clock);
        #2;
        if (trigger && !trig_prev) trig_cnt++;
        trig_prev = trigger;
        if (done) done_cnt++;
        if (out_valid && out_ready && !reset) begin
            check("pop_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("out_data", out_data, exp_q.pop_front());
        end
    end

    initial begin : stimulus
        int n;
        int d0;
        int t0;
        reset = 1'b1;
        start = 1'b0;
        start_addr = 8'h00;
        length = 16'd0;
        read_data = 8'h00;
        read_data_ready = 1'b0;
        read_data_flag_captured = 1'b0;
        spi_busy = 1'b0;
        out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state and constant outputs
        check("reset_active", active, 0);
        check("reset_trigger", trigger, 0);
        check("reset_flag", read_data_flag, 0);
        check("reset_done", done, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_addr", addr, 0);
        check("reset_out_data", out_data, 0);
        check("const_opcode", opcode, 8'h03);
        check("const_dummy", dummy_cycles, 0);
        check("const_addr_flag", addr_flag, 1);
        check("const_wdf", write_data_flag, 0);
        check("const_wdata", write_data, 0);

        // Single burst
        out_ready = 1'b1;
        src_q = '{8'h11, 8'h22, 8'h33};
        exp_q = '{8'h11, 8'h22, 8'h33};
        d0 = done_cnt;
        t0 = trig_cnt;
        do_start(8'hAB, 16'd3);
        check("sb_active", active, 1);
        check("sb_trigger_t1", trigger, 0);
        tick(1);
        check("sb_trigger_t2", trigger, 1);
        master_txn(0, 8'hAB, n);
        check("sb_bytes", n, 3);
        check("sb_flag_closed", read_data_flag, 0);
        tick(1);
        check("sb_done_early", done, 0);
        tick(1);
        check("sb_done", done, 1);
        tick(3);
        check("sb_done_count", done_cnt - d0, 1);
        check("sb_trig_count", trig_cnt - t0, 1);
        check("sb_drained", exp_q.size(), 0);
        check("sb_idle", active, 0);

        // Zero length
        d0 = done_cnt;
        t0 = trig_cnt;
        do_start(8'h55, 16'd0);
        check("zl_done", done, 1);
        check("zl_trigger", trigger, 0);
        tick(1);
        check("zl_done_drop", done, 0);
        check("zl_active", active, 0);
        check("zl_out_valid", out_valid, 0);
        tick(2);
        check("zl_done_count", done_cnt - d0, 1);
        check("zl_trig_count", trig_cnt - t0, 0);

        // Backpressure: FIFO limits the first transaction to 4 bytes
        out_ready = 1'b0;
        src_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
        exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49};
        d0 = done_cnt;
        do_start(8'hAB, 16'd10);
        master_txn(0, 8'hAB, n);
        check("bp_first_bytes", n, 4);
        tick(4);
        check("bp_wait_check", state_dbg, 1);
        check("bp_wait_trigger", trigger, 0);
        check("bp_head", out_data, 8'h40);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        master_txn(0, 8'hAF, n);
        check("bp_second_bytes", n, 6);
        tick(5);
        check("bp_done_count", done_cnt - d0, 1);
        check("bp_drained", exp_q.size(), 0);
        check("bp_overflow", overflow, 0);

        // Address wrap
        out_ready = 1'b0;
        src_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        do_start(8'hFD, 16'd6);
        master_txn(0, 8'hFD, n);
        check("wr_first_bytes", n, 4);
        out_ready = 1'b1;
        master_txn(0, 8'h01, n);
        check("wr_second_bytes", n, 2);
        tick(5);
        check("wr_drained", exp_q.size(), 0);

        // Start during RUN is ignored
        src_q = '{8'h70, 8'h71};
        exp_q = '{8'h70, 8'h71};
        d0 = done_cnt;
        do_start(8'h10, 16'd2);
        master_txn(1, 8'h10, n);
        check("si_bytes", n, 2);
        tick(5);
        check("si_done_count", done_cnt - d0, 1);
        check("si_drained", exp_q.size(), 0);
        check("si_idle", active, 0);

        // Reset during RUN
        out_ready = 1'b0;
        src_q = '{8'h90, 8'h91, 8'h92};
        d0 = done_cnt;
        t0 = trig_cnt;
        do_start(8'h30, 16'd3);
        master_txn(2, 8'h30, n);
        tick(5);
        src_q.delete();
        check("rr_no_done", done_cnt - d0, 0);
        check("rr_no_relaunch", trig_cnt - t0, 1);
        check("rr_idle", active, 0);

        // Overflow
        src_q = '{8'h80, 8'h81, 8'h82, 8'h83};
        exp_q = '{8'h80, 8'h81, 8'h82, 8'h83};
        do_start(8'h20, 16'd4);
        master_txn(0, 8'h20, n);
        check("ov_bytes", n, 4);
        tick(3);
        check("ov_pre_flag", overflow, 0);
        read_data = 8'h5A;
        read_data_ready = 1'b1;
        tick(1);
        read_data_ready = 1'b0;
        tick(1);
        check("ov_set", overflow, 1);
        check("ov_head_kept", out_data, 8'h80);
        tick(3);
        check("ov_sticky", overflow, 1);
        out_ready = 1'b1;
        tick(6);
        check("ov_drained", exp_q.size(), 0);
        check("ov_still_sticky", overflow, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("ov_cleared", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
